// File: rtl/mac_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_accum_if
// Description : Bus bundle for the multiply-accumulate block. It carries the
//               run control (start/len), the product handshake
//               (prod/prod_valid/prod_ready) and the result/status outputs.
//               master modport : the producer / controller side
//               slave modport  : the mac_accum side
// Parameters  : ACC_W - accumulator and result width (8..16)
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_accum_if #(
  parameter int ACC_W = 10
) ();

  logic             start;
  logic [3:0]       len;
  logic [6:0]       prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, len, prod, prod_valid,
    input  prod_ready, acc_out, busy, done, ovf
  );

  modport slave (
    input  start, len, prod, prod_valid,
    output prod_ready, acc_out, busy, done, ovf
  );

endinterface
`default_nettype wire

// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : mac_accum
// Description : Accumulates a run of unsigned 7-bit products from a 4x3
//               multiplier stage. A run is started from IDLE with a length
//               (0 encodes 16); each accepted product is added to the
//               accumulator, and after the last one the block spends one
//               cycle in DONE pulsing done before returning to IDLE.
//
// Ports       : clk             - clock, rising edge
//               rst_n           - asynchronous active-low reset
//               bus.start       - begin a run (sampled in IDLE only)
//               bus.len         - run length, 0 means 16
//               bus.prod        - product, 0..105
//               bus.prod_valid  - prod is valid
//               bus.prod_ready  - block accepts prod (high in ACC)
//               bus.acc_out     - accumulator value
//               bus.busy        - high in ACC and DONE
//               bus.done        - one-cycle completion pulse
//               bus.ovf         - sticky overflow flag of the current run
//
// Options     : MAC_ACCUM_SAT_EN - when defined the accumulator saturates at
//               2^ACC_W-1 on overflow; otherwise it wraps modulo 2^ACC_W.
// Parameters  : ACC_W - accumulator width, legal range 8..16
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accum #(
  parameter int ACC_W = 10
) (
  input wire        clk,
  input wire        rst_n,
  mac_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [4:0]       count_q, count_d;   // must hold 16
  logic             ovf_q,   ovf_d;

  logic             xfer;
  logic [ACC_W:0]   sum;
  logic             carry;

  // Datapath: one extra bit on the adder exposes the carry out of the MSB.
  always_comb begin
    xfer  = (state_q == S_ACC) && bus.prod_valid;
    sum   = {1'b0, acc_q} + {{(ACC_W - 6){1'b0}}, bus.prod};
    carry = sum[ACC_W];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        if (xfer) begin
          count_d = count_q - 5'd1;
          ovf_d   = ovf_q | carry;
`ifdef MAC_ACCUM_SAT_EN
          // Once clamped at the maximum, any further non-zero product
          // carries again, so the value stays pinned for the rest of the run.
          acc_d   = carry ? ACC_MAX : sum[ACC_W-1:0];
`else
          acc_d   = sum[ACC_W-1:0];
`endif
          // Leaving on the same edge as the final accumulate keeps the
          // done pulse exactly one cycle after the last product.
          if (count_q == 5'd1) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // All status outputs decode directly from registers, so reset forces
  // them low immediately.
  assign bus.prod_ready = (state_q == S_ACC);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;

endmodule
`default_nettype wire
